alu_mult_pipe: RTL

//  N-channel signed fixed-point multiply stage for the ALU datapath: int operand x per-channel coefficient.
//  Per-channel coefficient registers, 2-stage valid/ready pipeline, round-half-up, saturation, add-bypass.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/fx_mul_sat.sv | 45 ++++
 rtl/alu_mult_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared helpers for the ALU multiply stage: rounding constant, saturation bounds, channel slicing.
package alu_pkg;

  function automatic longint round_const(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic int chan_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply with round-half-up and optional saturation; purely combinational.
module fx_mul_sat
  import alu_pkg::*;
#(
  parameter int W      = 8,
  parameter int FRAC   = 7,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] c,
  output logic        [W-1:0] res,
  output logic                sat
);

  // One guard bit above the full product keeps the rounding add from overflowing.
  localparam int PW = 2 * W + 1;
  localparam logic signed [PW-1:0] RC   = PW'(round_const(FRAC));
  localparam logic signed [PW-1:0] MAXV = PW'(sat_max(W));
  localparam logic signed [PW-1:0] MINV = PW'(sat_min(W));

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] c_x;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] r;

  assign a_x = PW'(a);
  assign c_x = PW'(c);
  assign p   = a_x * c_x;
  assign r   = (p + RC) >>> FRAC;

  always_comb begin
    res = r[W-1:0];
    sat = 1'b0;
    if (SAT_EN) begin
      if (r > MAXV) begin
        res = MAXV[W-1:0];
        sat = 1'b1;
      end else if (r < MINV) begin
        res = MINV[W-1:0];
        sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mult_pipe.sv
// N-channel operand x coefficient multiply stage, 2-cycle valid/ready pipeline with add-bypass.
// Output stalls hold stable; in_ready drops only when both stages are full and downstream blocks.
module alu_mult_pipe
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int N_CH      = 2,
  parameter int FRAC_BITS = 7,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           coef_we,
  input  logic [BUS_WIDTH-1:0]      imm,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      f_add,
  input  logic [N_CH*BUS_WIDTH-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*BUS_WIDTH-1:0] mult_out,
  output logic [N_CH-1:0]           sat_flag
);

  localparam int W = BUS_WIDTH;

  logic [N_CH*W-1:0] coef_q;
  logic              s1_valid;
  logic              s1_add;
  logic [N_CH*W-1:0] s1_dat;
  logic [N_CH*W-1:0] s1_coef;
  logic [N_CH*W-1:0] mul_res;
  logic [N_CH-1:0]   mul_sat;
  logic              advance;
  logic              accept;

  assign advance  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || advance);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    fx_mul_sat #(
      .W      (W),
      .FRAC   (FRAC_BITS),
      .SAT_EN (SAT_EN)
    ) u_mul (
      .a   (s1_dat[chan_lsb(k, W) +: W]),
      .c   (s1_coef[chan_lsb(k, W) +: W]),
      .res (mul_res[chan_lsb(k, W) +: W]),
      .sat (mul_sat[k])
    );
  end

  // Coefficients are snapshotted into s1 so later writes never reach in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q    <= '0;
      s1_valid  <= 1'b0;
      s1_add    <= 1'b0;
      s1_dat    <= '0;
      s1_coef   <= '0;
      out_valid <= 1'b0;
      mult_out  <= '0;
      sat_flag  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (coef_we[k]) coef_q[k*W +: W] <= imm;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_add   <= f_add;
        s1_dat   <= data_in;
        s1_coef  <= coef_q;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        out_valid <= 1'b1;
        mult_out  <= s1_add ? s1_dat : mul_res;
        sat_flag  <= s1_add ? '0 : mul_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
